fifo: RTL and testbench
=======================

FIFO -- requirements
Module: fifo

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter DEPTH, default 16, meaning number of 16-bit entries; power of two; AW = log2(DEPTH).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 data_in  input  16  packet word to store.
REQ-006 rd  input  2  link response: 00 idle, 01 ack, 10 nak, 11 reserved (treated as idle).
REQ-007 wr  input  1  write strobe.
REQ-008 en  input  1  global enable; when 0, no state changes other than reset.
REQ-009 tim_out  input  1  replay-timer expiry.
REQ-010 rep  input  1  explicit replay request.
REQ-011 data_out  output  16  registered output word.
REQ-012 empty  output  1  occupancy == 0.
REQ-013 full  output  1  occupancy == DEPTH.
REQ-014 seq  output  12  sequence number assigned to the next accepted write.
REQ-015 rdy  output  1  data_out valid this cycle.
REQ-016 num_packets_to_replay  output  12  entries remaining in the current replay.
REQ-017 replay_index  output  AW  buffer address currently being replayed.

Function
REQ-018 Write: en=1, wr=1, full=0 -> mem[wptr] <= data_in; wptr and occupancy +1; seq +1, wrapping 4095->0. Write while full SHALL be dropped with no state change.
REQ-019 Ack: en=1, rd=01, empty=0, state IDLE -> data_out <= mem[rptr]; rdy=1 the next cycle; rptr +1; occupancy -1. Ack while empty SHALL be ignored with rdy=0.
REQ-020 Simultaneous accepted write and ack SHALL leave occupancy unchanged; full/empty SHALL be recomputed from the registered occupancy.
REQ-021 Replay trigger = en=1 and (rd=10 or rep=1 or tim_out=1 when enabled per REQ-031) while in IDLE with empty=0. The trigger SHALL take precedence over an ack in the same cycle; the ack is discarded.
REQ-022 States: IDLE, REPLAY. On trigger -> REPLAY; num_packets_to_replay <= occupancy; replay_index <= rptr.
REQ-023 Each REPLAY cycle with en=1 -> data_out <= mem[replay_index]; rdy=1 the next cycle; replay_index +1 mod DEPTH; num_packets_to_replay -1. Return to IDLE in the cycle it reaches 0.
REQ-024 Replay SHALL NOT modify rptr or occupancy. Entries are freed only by ack.
REQ-025 In REPLAY, acks and new triggers SHALL be ignored. Writes SHALL be accepted per REQ-018 but are not added to the in-progress replay.
REQ-026 A trigger while empty SHALL be ignored; the block stays in IDLE with num_packets_to_replay=0.
REQ-027 rdy SHALL be 0 in any cycle following one with no ack read or replay read. data_out SHALL hold its last value.
REQ-028 Pointers SHALL wrap modulo DEPTH.

Reset
REQ-029 rst=0 SHALL immediately force: data_out=0, rdy=0, empty=1, full=0, seq=0, num_packets_to_replay=0, replay_index=0, wptr=rptr=0, occupancy=0, state=IDLE. Memory contents are not reset.
REQ-030 Reset asserted during REPLAY SHALL abort the replay; the first edge after release SHALL be in IDLE.

Configuration
REQ-031 Macro FIFO_TIMEOUT_REPLAY_EN: defined -> tim_out is a replay trigger per REQ-021; undefined -> tim_out is ignored, and only nak and rep trigger replay.

Verification
REQ-032 Reset, en=1, write 0x0000..0x0004 on 5 cycles -> empty=0, full=0, seq=5.
REQ-033 After REQ-032, rd=01 for one cycle -> next cycle data_out=0x0000, rdy=1; occupancy 4. Subsequent rd=01 cycles -> 0x0001, 0x0002, ... in order.
REQ-034 After REQ-032, rd=10 for one cycle -> num_packets_to_replay=5, then data_out 0x0000..0x0004 on 5 consecutive cycles with rdy=1, then IDLE with num_packets_to_replay=0 and occupancy still 5.
REQ-035 Write 16 words -> full=1. A 17th write is dropped, seq stays 16, and 16 acks return the original 16 words.
REQ-036 rst=0 mid-replay -> all outputs at reset values immediately, with no further rdy pulses. en=0 with wr/rd/rep active -> no change in any output.

Source files
------------

// File: rtl/fifo.sv
// Retry FIFO: 16-bit entries freed only by ack, with a nak/rep-triggered replay of all outstanding entries.
// Optional macro FIFO_TIMEOUT_REPLAY_EN makes tim_out an additional replay trigger.
module fifo #(
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   data_in,
    input  logic [1:0]    rd,
    input  logic          wr,
    input  logic          en,
    input  logic          tim_out,
    input  logic          rep,
    output logic [15:0]   data_out,
    output logic          empty,
    output logic          full,
    output logic [11:0]   seq,
    output logic          rdy,
    output logic [11:0]   num_packets_to_replay,
    output logic [AW-1:0] replay_index
);

    typedef enum logic {
        IDLE   = 1'b0,
        REPLAY = 1'b1
    } state_t;

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [15:0] mem [DEPTH];

    state_t        state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   occ_q, occ_d;
    logic [11:0]   seq_q, seq_d;
    logic [11:0]   npr_q, npr_d;
    logic [AW-1:0] ridx_q, ridx_d;
    logic [15:0]   data_out_q, data_out_d;
    logic          rdy_q, rdy_d;

    logic          tout;
    logic          wr_acc;
    logic          trigger;
    logic          ack;

`ifdef FIFO_TIMEOUT_REPLAY_EN
    assign tout = tim_out;
`else
    logic unused_tim_out;
    assign unused_tim_out = tim_out;
    assign tout           = 1'b0;
`endif

    assign empty = (occ_q == '0);
    assign full  = (occ_q == FULL_CNT);

    // A trigger wins over an ack in the same cycle; both only act from IDLE with data held.
    assign wr_acc  = en && wr && !full;
    assign trigger = en && (state_q == IDLE) && !empty && ((rd == 2'b10) || rep || tout);
    assign ack     = en && (state_q == IDLE) && !empty && (rd == 2'b01) && !trigger;

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        occ_d      = occ_q;
        seq_d      = seq_q;
        npr_d      = npr_q;
        ridx_d     = ridx_q;
        data_out_d = data_out_q;
        rdy_d      = en ? 1'b0 : rdy_q;

        if (wr_acc) begin
            wptr_d = wptr_q + PTR_ONE;
            seq_d  = seq_q + 12'd1;
        end

        case ({wr_acc, ack})
            2'b10:   occ_d = occ_q + CNT_ONE;
            2'b01:   occ_d = occ_q - CNT_ONE;
            default: occ_d = occ_q;
        endcase

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = REPLAY;
                    npr_d   = 12'(occ_q);
                    ridx_d  = rptr_q;
                end else if (ack) begin
                    data_out_d = mem[rptr_q];
                    rdy_d      = 1'b1;
                    rptr_d     = rptr_q + PTR_ONE;
                end
            end
            REPLAY: begin
                if (en) begin
                    data_out_d = mem[ridx_q];
                    rdy_d      = 1'b1;
                    ridx_d     = ridx_q + PTR_ONE;
                    npr_d      = (npr_q == 12'd0) ? 12'd0 : npr_q - 12'd1;
                    if (npr_q <= 12'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            occ_q      <= '0;
            seq_q      <= '0;
            npr_q      <= '0;
            ridx_q     <= '0;
            data_out_q <= '0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            occ_q      <= occ_d;
            seq_q      <= seq_d;
            npr_q      <= npr_d;
            ridx_q     <= ridx_d;
            data_out_q <= data_out_d;
            rdy_q      <= rdy_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr_q] <= data_in;
        end
    end

    assign data_out              = data_out_q;
    assign rdy                   = rdy_q;
    assign seq                   = seq_q;
    assign num_packets_to_replay = npr_q;
    assign replay_index          = ridx_q;

endmodule

// File: tb/tb_fifo.sv
// Directed self-checking bench for the retry FIFO at DEPTH=16.
module tb_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clk;
    logic          rst;
    logic [15:0]   data_in;
    logic [1:0]    rd;
    logic          wr;
    logic          en;
    logic          tim_out;
    logic          rep;
    logic [15:0]   data_out;
    logic          empty;
    logic          full;
    logic [11:0]   seq;
    logic          rdy;
    logic [11:0]   num_packets_to_replay;
    logic [AW-1:0] replay_index;

    int checkCount = 0;
    int failCount  = 0;

    fifo #(.DEPTH(DEPTH)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .data_in               (data_in),
        .rd                    (rd),
        .wr                    (wr),
        .en                    (en),
        .tim_out               (tim_out),
        .rep                   (rep),
        .data_out              (data_out),
        .empty                 (empty),
        .full                  (full),
        .seq                   (seq),
        .rdy                   (rdy),
        .num_packets_to_replay (num_packets_to_replay),
        .replay_index          (replay_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample 1ns after the rising edge.
    task automatic applyStimulus(input logic w, input logic [1:0] r, input logic p,
                                 input logic t, input logic [15:0] d);
        wr      = w;
        rd      = r;
        rep     = p;
        tim_out = t;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        en      = 1'b1;
        wr      = 1'b0;
        rd      = 2'b00;
        rep     = 1'b0;
        tim_out = 1'b0;
        data_in = 16'h0;
        rst     = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        en      = 1'b0;
        wr      = 1'b0;
        rd      = 2'b00;
        rep     = 1'b0;
        tim_out = 1'b0;
        data_in = 16'h0;
        rst     = 1'b0;
        #3;
        checkOutput("rst_data_out", 32'(data_out), 32'h0);
        checkOutput("rst_rdy", 32'(rdy), 32'h0);
        checkOutput("rst_empty", 32'(empty), 32'h1);
        checkOutput("rst_full", 32'(full), 32'h0);
        checkOutput("rst_seq", 32'(seq), 32'h0);
        checkOutput("rst_npr", 32'(num_packets_to_replay), 32'h0);
        checkOutput("rst_ridx", 32'(replay_index), 32'h0);

        // Basic writes followed by in-order acks
        resetDut();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 16'(i));
        checkOutput("w5_empty", 32'(empty), 32'h0);
        checkOutput("w5_full", 32'(full), 32'h0);
        checkOutput("w5_seq", 32'(seq), 32'd5);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 16'h0);
        checkOutput("idle_rdy", 32'(rdy), 32'h0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 2'b01, 1'b0, 1'b0, 16'h0);
            checkOutput("ack_data", 32'(data_out), 32'(i));
            checkOutput("ack_rdy", 32'(rdy), 32'h1);
        end
        checkOutput("ack_all_empty", 32'(empty), 32'h1);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 16'h0);
        checkOutput("post_ack_rdy", 32'(rdy), 32'h0);
        checkOutput("post_ack_hold", 32'(data_out), 32'h4);

        // Nak-triggered replay of five entries
        resetDut();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 16'(i));
        applyStimulus(1'b0, 2'b10, 1'b0, 1'b0, 16'h0);
        checkOutput("nak_npr", 32'(num_packets_to_replay), 32'd5);
        checkOutput("nak_ridx", 32'(replay_index), 32'd0);
        checkOutput("nak_rdy", 32'(rdy), 32'h0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, (i == 1) ? 2'b01 : 2'b00, 1'b0, 1'b0, 16'h0);
            checkOutput("rpl_data", 32'(data_out), 32'(i));
            checkOutput("rpl_rdy", 32'(rdy), 32'h1);
            checkOutput("rpl_npr", 32'(num_packets_to_replay), 32'(4 - i));
            checkOutput("rpl_ridx", 32'(replay_index), 32'(i + 1));
        end
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 16'h0);
        checkOutput("rpl_end_rdy", 32'(rdy), 32'h0);
        checkOutput("rpl_end_hold", 32'(data_out), 32'h4);
        checkOutput("rpl_end_empty", 32'(empty), 32'h0);
`ifndef FIFO_TIMEOUT_REPLAY_EN
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 16'h0);
        checkOutput("tout_ignored_npr", 32'(num_packets_to_replay), 32'h0);
        checkOutput("tout_ignored_rdy", 32'(rdy), 32'h0);
`endif
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 2'b01, 1'b0, 1'b0, 16'h0);
            checkOutput("rpl_ack_data", 32'(data_out), 32'(i));
        end
        checkOutput("rpl_ack_empty", 32'(empty), 32'h1);

        // Fill to capacity, drop one write, drain, then nak while empty
        resetDut();
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 16'hA000 + 16'(i));
        checkOutput("fill_full", 32'(full), 32'h1);
        checkOutput("fill_seq", 32'(seq), 32'd16);
        applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 16'hFFFF);
        checkOutput("drop_full", 32'(full), 32'h1);
        checkOutput("drop_seq", 32'(seq), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 2'b01, 1'b0, 1'b0, 16'h0);
            checkOutput("drain_data", 32'(data_out), 32'hA000 + 32'(i));
        end
        checkOutput("drain_empty", 32'(empty), 32'h1);
        checkOutput("drain_full", 32'(full), 32'h0);
        applyStimulus(1'b0, 2'b10, 1'b0, 1'b0, 16'h0);
        checkOutput("nak_empty_npr", 32'(num_packets_to_replay), 32'h0);
        checkOutput("nak_empty_rdy", 32'(rdy), 32'h0);

        // Rep-triggered replay aborted by reset
        resetDut();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 16'h00A0 + 16'(i));
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 16'h0);
        checkOutput("rep_npr", 32'(num_packets_to_replay), 32'd3);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 16'h0);
        checkOutput("rep_data", 32'(data_out), 32'h00A0);
        checkOutput("rep_rdy", 32'(rdy), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("abort_data", 32'(data_out), 32'h0);
        checkOutput("abort_rdy", 32'(rdy), 32'h0);
        checkOutput("abort_npr", 32'(num_packets_to_replay), 32'h0);
        checkOutput("abort_ridx", 32'(replay_index), 32'h0);
        checkOutput("abort_empty", 32'(empty), 32'h1);
        checkOutput("abort_seq", 32'(seq), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 16'h0);
        checkOutput("abort_after_rdy", 32'(rdy), 32'h0);
        checkOutput("abort_after_npr", 32'(num_packets_to_replay), 32'h0);

        // Enable low freezes everything; then simultaneous write and ack
        applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 16'h1111);
        applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 16'h2222);
        en = 1'b0;
        applyStimulus(1'b1, 2'b01, 1'b1, 1'b1, 16'h9999);
        applyStimulus(1'b1, 2'b10, 1'b1, 1'b1, 16'h9999);
        checkOutput("en0_seq", 32'(seq), 32'd2);
        checkOutput("en0_rdy", 32'(rdy), 32'h0);
        checkOutput("en0_data", 32'(data_out), 32'h0);
        checkOutput("en0_npr", 32'(num_packets_to_replay), 32'h0);
        checkOutput("en0_empty", 32'(empty), 32'h0);
        en = 1'b1;
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 16'h3333);
        checkOutput("wa_data", 32'(data_out), 32'h1111);
        checkOutput("wa_seq", 32'(seq), 32'd3);
        applyStimulus(1'b0, 2'b01, 1'b0, 1'b0, 16'h0);
        checkOutput("wa_ack2", 32'(data_out), 32'h2222);
        applyStimulus(1'b0, 2'b01, 1'b0, 1'b0, 16'h0);
        checkOutput("wa_ack3", 32'(data_out), 32'h3333);
        checkOutput("wa_empty", 32'(empty), 32'h1);
        applyStimulus(1'b0, 2'b01, 1'b0, 1'b0, 16'h0);
        checkOutput("ack_empty_rdy", 32'(rdy), 32'h0);
        checkOutput("ack_empty_hold", 32'(data_out), 32'h3333);

        $display("test done: total=%0d bad=%0d", checkCount, failCount);
        $finish;
    end

endmodule
